// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared types and constants for the gate1 3-bit mux select/data TDR.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Optional build macro: FIREBIRD7_IN_GATE1_TDR_PARITY_EN adds a parity bit at the chain MSB.
package firebird7_in_gate1_tdr_pkg;

  localparam int TDR_DATA_W = 3;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  localparam int TDR_LEN = TDR_DATA_W + 2;  // {parity, sel, data}
`else
  localparam int TDR_LEN = TDR_DATA_W + 1;  // {sel, data}
`endif

  // Update-register layout; bit order matches the low TDR_DATA_W+1 chain bits.
  typedef struct packed {
    logic                  sel;
    logic [TDR_DATA_W-1:0] data;
  } tdr_upd_t;

  // Parity bit value that makes {parity, sel, data} carry an even number of ones.
  function automatic logic tdr_even_parity(input tdr_upd_t v);
    return ^v;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_sel.sv
// IJTAG TDR driving select/data of the gate1 3-bit IJTAG data mux; capture reads back mux data_out.
// Latency: scan out comes straight from the shift flop; update outputs change 1 cycle after the ue edge.
// Backpressure: none; ijtag_sel=0 freezes all state, ijtag_reset overrides every enable.
//
// Ports:
//   ijtag_tck        TDR clock, all state on the rising edge
//   ijtag_reset      synchronous active-high reset
//   ijtag_sel/ce/se/ue  segment select, capture, shift and update enables
//   ijtag_si/so      scan in / scan out (so = shift_q[0])
//   capture_data_in  readback of the mux data_out
//   ijtag_select     update-register select bit to the mux
//   ijtag_data_out   update-register data to the mux ijtag_data_in
//
// Build macro FIREBIRD7_IN_GATE1_TDR_PARITY_EN: chain gains an even-parity bit at its MSB;
// updates with a bad parity bit are dropped and raise a sticky error that the next capture
// reports in the parity position and then clears.
module firebird7_in_gate1_tessent_tdr_w3_sel
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int                DATA_W     = TDR_DATA_W,
  parameter logic [DATA_W-1:0] DATA_RESET = '0,
  parameter logic              SEL_RESET  = 1'b0
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [DATA_W-1:0] capture_data_in,
  output logic              ijtag_select,
  output logic [DATA_W-1:0] ijtag_data_out
);

  // Chain length follows the package choice, rebased on this instance's data width.
  localparam int L = DATA_W + (TDR_LEN - TDR_DATA_W);

  logic [L-1:0] shift_q, shift_d;
  tdr_upd_t     upd_q, upd_d;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  logic         perr_q, perr_d;
  logic         par_ok;

  // Parity is judged on the pre-edge chain contents, the same value an update would load.
  assign par_ok = (shift_q[L-1] == tdr_even_parity(shift_q[DATA_W:0]));
`endif

  always_comb begin
    shift_d = shift_q;
    upd_d   = upd_q;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    perr_d  = perr_q;
`endif
    if (ijtag_sel) begin
      // Capture has priority over shift.
      if (ijtag_ce) begin
        shift_d[DATA_W-1:0] = capture_data_in;
        shift_d[DATA_W]     = upd_q.sel;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        shift_d[L-1]        = perr_q;
        perr_d              = 1'b0;
`endif
      end else if (ijtag_se) begin
        shift_d = {ijtag_si, shift_q[L-1:1]};
      end

      // Update is independent of capture/shift and always loads the pre-edge chain.
      if (ijtag_ue) begin
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        // Evaluated after capture so a fresh error in the same cycle is not lost by the clear.
        if (par_ok) begin
          upd_d = shift_q[DATA_W:0];
        end else begin
          perr_d = 1'b1;
        end
`else
        upd_d = shift_q[DATA_W:0];
`endif
      end
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      shift_q    <= '0;
      upd_q.sel  <= SEL_RESET;
      upd_q.data <= DATA_RESET;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      upd_q      <= upd_d;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign ijtag_so       = shift_q[0];
  assign ijtag_select   = upd_q.sel;
  assign ijtag_data_out = upd_q.data;

endmodule
